// File: rtl/au_op_sequencer.sv
// au_op_sequencer: sequencing controller for the 32-bit arithmetic unit.
// It accepts one operation at a time and drives the shared operands and the
// add/sub control. It pulses start to the iterative multiply or divide unit
// and waits for done, bounded by a watchdog. The result is returned with
// zero and error flags.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_op 00 ADD 01 SUB 10 MULT 11 DIV
//   req_a, req_b           request operands
//   op_a, op_b             registered operands to all function units
//   addsub_ctrl            0 add, 1 sub
//   s_in                   combinational add/sub result
//   mult_start, div_start  single-cycle start pulses
//   mult_done, div_done    unit completion (honoured only while waiting)
//   hi_in, lo_in           unit result (mult hi/lo, div remainder/quotient)
//   rsp_valid/rsp_ready    response handshake
//   rsp_s, rsp_hi, rsp_lo  result registers
//   rsp_zero, rsp_err      result-is-zero, divide-by-zero or timeout
module au_op_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        addsub_ctrl,
  input  logic [31:0] s_in,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_s,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rsp_s_q, rsp_s_d;
  logic [31:0]   rsp_hi_q, rsp_hi_d;
  logic [31:0]   rsp_lo_q, rsp_lo_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_err_q, rsp_err_d;
  logic          done_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      rsp_s_q    <= '0;
      rsp_hi_q   <= '0;
      rsp_lo_q   <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      rsp_s_q    <= rsp_s_d;
      rsp_hi_q   <= rsp_hi_d;
      rsp_lo_q   <= rsp_lo_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    rsp_s_d    = rsp_s_q;
    rsp_hi_d   = rsp_hi_q;
    rsp_lo_d   = rsp_lo_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    mult_start = 1'b0;
    div_start  = 1'b0;
    // Only the unit that was issued is listened to; op_q[0] selects DIV.
    done_sel   = op_q[0] ? div_done : mult_done;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          op_a_d  = req_a;
          op_b_d  = req_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = '0;
        if (!op_q[1]) begin
          rsp_s_d    = s_in;
          rsp_hi_d   = '0;
          rsp_lo_d   = '0;
          rsp_zero_d = (s_in == '0);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (!op_q[0]) begin
          mult_start = 1'b1;
          state_d    = WAIT;
        end else if (op_b_q == '0) begin
          // Divide by zero never reaches the divider.
          rsp_s_d    = '1;
          rsp_hi_d   = op_a_q;
          rsp_lo_d   = '1;
          rsp_zero_d = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          div_start = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Done takes priority over a timeout in the same cycle.
        if (done_sel) begin
          rsp_s_d    = lo_in;
          rsp_hi_d   = hi_in;
          rsp_lo_d   = lo_in;
          rsp_zero_d = (hi_in == '0) && (lo_in == '0);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == LAST_CNT) begin
          rsp_s_d    = '0;
          rsp_hi_d   = '0;
          rsp_lo_d   = '0;
          rsp_zero_d = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign addsub_ctrl = op_q[0];
  assign rsp_s       = rsp_s_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_lo      = rsp_lo_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_au_op_sequencer.sv
module tb_au_op_sequencer;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] op_a, op_b;
  logic        addsub_ctrl;
  logic [31:0] s_in;
  logic        mult_start, div_start;
  logic        mult_done = 1'b0, div_done = 1'b0;
  logic [31:0] hi_in = '0, lo_in = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_s, rsp_hi, rsp_lo;
  logic        rsp_zero, rsp_err;

  au_op_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .op_a(op_a), .op_b(op_b), .addsub_ctrl(addsub_ctrl), .s_in(s_in),
    .mult_start(mult_start), .div_start(div_start),
    .mult_done(mult_done), .div_done(div_done),
    .hi_in(hi_in), .lo_in(lo_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Adder model fed from the registered operands.
  assign s_in = addsub_ctrl ? (op_a - op_b) : (op_a + op_b);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level expectations maintained by the transaction model.
  bit          chk_on = 1'b0;
  logic        exp_req_ready = 1'b1, exp_rsp_valid = 1'b0;
  logic        exp_mult_start = 1'b0, exp_div_start = 1'b0;
  logic [31:0] exp_op_a = '0, exp_op_b = '0;
  logic        exp_addsub = 1'b0;
  bit          exp_resp_chk = 1'b0;
  logic [31:0] exp_s, exp_hi, exp_lo;
  logic        exp_zero, exp_err;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      chk("mult_start", mult_start, exp_mult_start);
      chk("div_start", div_start, exp_div_start);
      chk("op_a", op_a, exp_op_a);
      chk("op_b", op_b, exp_op_b);
      chk("addsub_ctrl", addsub_ctrl, exp_addsub);
      if (exp_resp_chk) begin
        chk("rsp_s", rsp_s, exp_s);
        chk("rsp_hi", rsp_hi, exp_hi);
        chk("rsp_lo", rsp_lo, exp_lo);
        chk("rsp_zero", rsp_zero, exp_zero);
        chk("rsp_err", rsp_err, exp_err);
      end
    end
  end

  // One complete transaction. done_k >= TO means the unit never finishes.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int done_k, input bit spur, input int bp,
                        output logic [31:0] o_s, output logic [31:0] o_hi,
                        output logic [31:0] o_lo, output logic o_zero,
                        output logic o_err, output int lat);
    logic [63:0] prod;
    logic [31:0] uhi, ulo;
    bit waits, issued;
    int L;
    prod = {32'd0, a} * {32'd0, b};
    waits = (op == 2'b10) || (op == 2'b11 && b != 0);
    if (op == 2'b11 && b != 0) begin uhi = a % b; ulo = a / b; end
    else begin uhi = prod[63:32]; ulo = prod[31:0]; end
    // Expected response from the operation's arithmetic meaning.
    case (op)
      2'b00: begin exp_s = a + b; exp_hi = 0; exp_lo = 0; exp_err = 0; exp_zero = (a + b == 0); end
      2'b01: begin exp_s = a - b; exp_hi = 0; exp_lo = 0; exp_err = 0; exp_zero = (a == b); end
      default: begin
        if (op == 2'b11 && b == 0) begin
          exp_s = 32'hFFFF_FFFF; exp_hi = a; exp_lo = 32'hFFFF_FFFF; exp_zero = 0; exp_err = 1;
        end else if (done_k >= int'(TO)) begin
          exp_s = 0; exp_hi = 0; exp_lo = 0; exp_zero = 0; exp_err = 1;
        end else begin
          exp_s = ulo; exp_hi = uhi; exp_lo = ulo; exp_zero = (uhi == 0 && ulo == 0); exp_err = 0;
        end
      end
    endcase
    lat = -1;
    // Request cycle
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
    exp_op_a = a; exp_op_b = b; exp_addsub = op[0];
    // Execute cycle: done here must be ignored
    L = 1;
    exp_req_ready = 1'b0;
    exp_mult_start = (op == 2'b10);
    exp_div_start = (op == 2'b11) && (b != 0);
    mult_done = 1'($urandom); div_done = 1'($urandom);
    hi_in = $urandom; lo_in = $urandom;
    @(posedge clk); #1; L++;
    exp_mult_start = 1'b0; exp_div_start = 1'b0;
    if (waits) begin
      for (int k = 0; k < int'(TO); k++) begin
        issued = (k == done_k);
        hi_in = issued ? uhi : $urandom;
        lo_in = issued ? ulo : $urandom;
        if (op == 2'b10) begin mult_done = issued; div_done = spur ? 1'($urandom) : 1'b0; end
        else begin div_done = issued; mult_done = spur ? 1'($urandom) : 1'b0; end
        @(posedge clk); #1; L++;
        if (issued) break;
      end
    end
    // Response phase with optional backpressure
    exp_rsp_valid = 1'b1; exp_resp_chk = 1'b1;
    for (int c = 0; c <= bp; c++) begin
      rsp_ready = (c == bp);
      mult_done = 1'($urandom); div_done = 1'($urandom);
      hi_in = $urandom; lo_in = $urandom;
      if (rsp_valid && lat < 0) begin
        lat = L; o_s = rsp_s; o_hi = rsp_hi; o_lo = rsp_lo; o_zero = rsp_zero; o_err = rsp_err;
      end
      @(posedge clk); #1; L++;
    end
    if (lat < 0) begin
      o_s = 'x; o_hi = 'x; o_lo = 'x; o_zero = 1'bx; o_err = 1'bx;
    end
    rsp_ready = 1'b0; mult_done = 1'b0; div_done = 1'b0;
    exp_rsp_valid = 1'b0; exp_resp_chk = 1'b0; exp_req_ready = 1'b1;
  endtask

  logic [31:0] s, hi, lo;
  logic        z, e;
  int          lat;

  initial begin
    // Reset state
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_starts", {mult_start, div_start}, 0);
    chk("rst_ops", {op_a, op_b, addsub_ctrl}, 0);
    chk("rst_rsp", {rsp_s, rsp_zero, rsp_err}, 0);
    chk("rst_rsp_hilo", {rsp_hi, rsp_lo}, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_on = 1'b1;

    // Directed cases with hand-computed values
    run_op(2'b00, 32'd5, 32'd7, 0, 0, 0, s, hi, lo, z, e, lat);
    chk("add_s", s, 32'd12); chk("add_hilo", {hi, lo}, 0);
    chk("add_flags", {z, e}, 2'b00); chk("add_lat", lat, 2);
    chk("add_next_ready", req_ready, 1);

    run_op(2'b01, 32'd3, 32'd3, 0, 0, 1, s, hi, lo, z, e, lat);
    chk("sub_zero_s", s, 0); chk("sub_zero_z", z, 1);
    run_op(2'b01, 32'd0, 32'd1, 0, 0, 0, s, hi, lo, z, e, lat);
    chk("sub_neg_s", s, 32'hFFFF_FFFF); chk("sub_neg_z", z, 0);

    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 5, 1, 0, s, hi, lo, z, e, lat);
    chk("mult_hi", hi, 1); chk("mult_lo", lo, 32'hFFFF_FFFE);
    chk("mult_flags", {z, e}, 2'b00); chk("mult_lat", lat, 8);

    run_op(2'b11, 32'd17, 32'd5, 2, 1, 0, s, hi, lo, z, e, lat);
    chk("div_hi", hi, 2); chk("div_lo", lo, 3); chk("div_lat", lat, 5);

    run_op(2'b11, 32'd9, 32'd0, 0, 0, 0, s, hi, lo, z, e, lat);
    chk("div0_err", e, 1); chk("div0_hi", hi, 9); chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_lat", lat, 2);

    run_op(2'b10, 32'd6, 32'd7, 100, 0, 0, s, hi, lo, z, e, lat);
    chk("tmo_lat", lat, 10); chk("tmo_err", e, 1);
    chk("tmo_res", {s, hi, lo, z}, 0);

    run_op(2'b10, 32'h1234_5678, 32'd16, int'(TO) - 1, 0, 0, s, hi, lo, z, e, lat);
    chk("last_cnt_err", e, 0); chk("last_cnt_hi", hi, 1);
    chk("last_cnt_lo", lo, 32'h2345_6780); chk("last_cnt_lat", lat, 10);

    run_op(2'b00, 32'd40, 32'd2, 0, 0, 5, s, hi, lo, z, e, lat);
    chk("bp_s", s, 32'd42);

    // Reset while waiting on the multiplier
    req_op = 2'b10; req_a = 32'd7; req_b = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_op_a = 32'd7; exp_op_b = 32'd9; exp_addsub = 1'b0;
    exp_req_ready = 1'b0; exp_mult_start = 1'b1;
    @(posedge clk); #1;
    exp_mult_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_req_ready = 1'b1; exp_op_a = '0; exp_op_b = '0; exp_addsub = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0); chk("abort_req_ready", req_ready, 1);
    chk("abort_start", mult_start, 0); chk("abort_rsp_s", rsp_s, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mult_done = 1'b1; hi_in = 32'hDEAD; lo_in = 32'hBEEF;
    @(posedge clk); #1;
    mult_done = 1'b0;
    chk("late_done_ignored", {req_ready, rsp_valid}, 2'b10);
    run_op(2'b00, 32'd100, 32'd23, 0, 0, 0, s, hi, lo, z, e, lat);
    chk("post_abort_add", s, 32'd123); chk("post_abort_lat", lat, 2);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 3) == 0) b = (op == 2'b01) ? a : 32'd0;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mult_done = 1'($urandom); div_done = 1'($urandom);
        @(posedge clk); #1;
      end
      mult_done = 1'b0; div_done = 1'b0;
      run_op(op, a, b, $urandom_range(0, TO + 1), 1'($urandom), $urandom_range(0, 3),
             s, hi, lo, z, e, lat);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
